// File: rtl/mem_game_pkg.sv
// Shared types for the memory tester game: checker states, digits and BCD score.
// Used by seq_checker and its optional BCD score incrementer.
package mem_game_pkg;

  localparam int MAX_SEQ_DEF = 8;
  localparam int PTR_W       = 4;

  typedef logic [3:0]       digit_t;
  typedef logic [7:0]       bcd2_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_ENTRY,
    S_WIN,
    S_LOSE
  } chk_state_t;

  function automatic logic bcd_top(input digit_t d);
    return d >= 4'd9;
  endfunction

endpackage

// File: rtl/bcd2_sat_inc.sv
// Two-digit packed BCD incrementer that saturates at 99.
// Only built when the score feature is enabled in seq_checker.
module bcd2_sat_inc
  import mem_game_pkg::*;
(
  input  bcd2_t a,
  output bcd2_t y
);

  always_comb begin
    y = a;
    if (bcd_top(a[3:0]) && bcd_top(a[7:4])) begin
      y = 8'h99;
    end else if (bcd_top(a[3:0])) begin
      y[3:0] = 4'd0;
      y[7:4] = a[7:4] + 4'd1;
    end else begin
      y[3:0] = a[3:0] + 4'd1;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Captures flashed digits and checks the player's key entries against them.
// Optional BCD running score is built when SEQ_CHECKER_SCORE_EN is defined.
module seq_checker
  import mem_game_pkg::*;
#(
  parameter int MAX_SEQ = MAX_SEQ_DEF
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       enable,
  input  logic       shl,
  input  logic [4:0] flash_num,
  input  logic       begin_timer,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       time_stop,
  input  logic       logout,
  output logic       win,
  output logic       loose,
  output logic [3:0] digits_entered,
  output logic [3:0] expected_cnt,
  output logic [7:0] score
);

  localparam int   AW    = $clog2(MAX_SEQ);
  localparam ptr_t MAX_P = ptr_t'(MAX_SEQ);

  chk_state_t state, state_n;
  ptr_t       wr_ptr, wr_n;
  ptr_t       rd_ptr, rd_n;
  logic       win_q, win_n;
  logic       loose_q, loose_n;
  logic       wr_en;
  logic       hit;
  logic       score_clr;
  digit_t     mem [MAX_SEQ];
  digit_t     exp_digit;

  // bit 4 of the flashed value carries no digit information
  logic unused_flash_msb;
  assign unused_flash_msb = flash_num[4];

  assign exp_digit = mem[rd_ptr[AW-1:0]];

  always_comb begin
    state_n   = state;
    wr_n      = wr_ptr;
    rd_n      = rd_ptr;
    win_n     = win_q;
    loose_n   = loose_q;
    wr_en     = 1'b0;
    hit       = 1'b0;
    score_clr = 1'b0;
    if (logout) begin
      state_n   = S_IDLE;
      wr_n      = '0;
      rd_n      = '0;
      win_n     = 1'b0;
      loose_n   = 1'b0;
      score_clr = 1'b1;
    end else begin
      unique case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (enable) begin
            state_n = S_CAPTURE;
            wr_n    = '0;
            rd_n    = '0;
            win_n   = 1'b0;
            loose_n = 1'b0;
          end
        end
        S_CAPTURE: begin
          if (shl && (wr_ptr < MAX_P)) begin
            wr_en = 1'b1;
            wr_n  = wr_ptr + ptr_t'(1);
          end
          // decide on the post-capture count
          if (begin_timer) begin
            if (wr_n == '0) begin
              state_n = S_LOSE;
              loose_n = 1'b1;
            end else begin
              state_n = S_ENTRY;
            end
          end
        end
        S_ENTRY: begin
          if (key_valid) begin
            if (key_code == exp_digit) begin
              hit  = 1'b1;
              rd_n = rd_ptr + ptr_t'(1);
              if (rd_n == wr_ptr) begin
                state_n = S_WIN;
                win_n   = 1'b1;
              end else if (time_stop) begin
                state_n = S_LOSE;
                loose_n = 1'b1;
              end
            end else begin
              state_n = S_LOSE;
              loose_n = 1'b1;
            end
          end else if (time_stop) begin
            state_n = S_LOSE;
            loose_n = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      win_q   <= 1'b0;
      loose_q <= 1'b0;
    end else begin
      state   <= state_n;
      wr_ptr  <= wr_n;
      rd_ptr  <= rd_n;
      win_q   <= win_n;
      loose_q <= loose_n;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= flash_num[3:0];
    end
  end

  assign win            = win_q;
  assign loose          = loose_q;
  assign digits_entered = rd_ptr;
  assign expected_cnt   = wr_ptr;

`ifdef SEQ_CHECKER_SCORE_EN
  bcd2_t score_q;
  bcd2_t score_inc;

  bcd2_sat_inc u_inc (
    .a (score_q),
    .y (score_inc)
  );

  // score survives new rounds; only reset or logout clear it
  always_ff @(posedge clock) begin
    if (!rst) begin
      score_q <= '0;
    end else if (score_clr) begin
      score_q <= '0;
    end else if (hit) begin
      score_q <= score_inc;
    end
  end

  assign score = score_q;
`else
  logic unused_score;
  assign unused_score = hit ^ score_clr;
  assign score = 8'h00;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Directed self-checking bench for seq_checker.
// Score expectations follow SEQ_CHECKER_SCORE_EN when it is defined.
module tb_seq_checker;

  logic       clock = 1'b0;
  logic       rst;
  logic       enable;
  logic       shl;
  logic [4:0] flash_num;
  logic       begin_timer;
  logic       key_valid;
  logic [3:0] key_code;
  logic       time_stop;
  logic       logout;
  logic       win;
  logic       loose;
  logic [3:0] digits_entered;
  logic [3:0] expected_cnt;
  logic [7:0] score;

  int total = 0;
  int bad   = 0;

`ifdef SEQ_CHECKER_SCORE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  seq_checker dut (
    .clock          (clock),
    .rst            (rst),
    .enable         (enable),
    .shl            (shl),
    .flash_num      (flash_num),
    .begin_timer    (begin_timer),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .time_stop      (time_stop),
    .logout         (logout),
    .win            (win),
    .loose          (loose),
    .digits_entered (digits_entered),
    .expected_cnt   (expected_cnt),
    .score          (score)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] sc(input logic [7:0] v);
    return SC ? v : 8'h00;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_enable();
    enable = 1'b1;
    cyc();
    enable = 1'b0;
  endtask

  task automatic do_shl(input logic [4:0] d);
    shl       = 1'b1;
    flash_num = d;
    cyc();
    shl = 1'b0;
  endtask

  task automatic do_bt();
    begin_timer = 1'b1;
    cyc();
    begin_timer = 1'b0;
  endtask

  task automatic do_key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc();
    cyc();
    total++;
    if ({win, loose, digits_entered, expected_cnt, score} !== 18'd0) begin
      bad++;
      $display("FAIL reset: got win=%b loose=%b de=%0d ec=%0d score=%h want all 0",
               win, loose, digits_entered, expected_cnt, score);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_match();
    do_enable();
    do_shl(5'd3);
    do_shl(5'h17);
    do_shl(5'd1);
    total++;
    if (expected_cnt !== 4'd3) begin
      bad++;
      $display("FAIL match_cnt: got %0d want 3", expected_cnt);
    end
    do_bt();
    do_key(4'd3);
    total++;
    if (digits_entered !== 4'd1 || win !== 1'b0) begin
      bad++;
      $display("FAIL match_first: got de=%0d win=%b want de=1 win=0", digits_entered, win);
    end
    do_key(4'd7);
    do_key(4'd1);
    total++;
    if (win !== 1'b1 || loose !== 1'b0 || digits_entered !== 4'd3) begin
      bad++;
      $display("FAIL match_win: got win=%b loose=%b de=%0d want 1 0 3", win, loose, digits_entered);
    end
    total++;
    if (score !== sc(8'h03)) begin
      bad++;
      $display("FAIL match_score: got %h want %h", score, sc(8'h03));
    end
  endtask

  task automatic test_mismatch();
    do_enable();
    total++;
    if (win !== 1'b0 || expected_cnt !== 4'd0) begin
      bad++;
      $display("FAIL restart: got win=%b ec=%0d want 0 0", win, expected_cnt);
    end
    do_shl(5'd5);
    do_shl(5'd2);
    do_bt();
    do_key(4'd5);
    do_key(4'd9);
    total++;
    if (loose !== 1'b1 || win !== 1'b0 || digits_entered !== 4'd1) begin
      bad++;
      $display("FAIL mismatch: got loose=%b win=%b de=%0d want 1 0 1", loose, win, digits_entered);
    end
    do_key(4'd2);
    total++;
    if (loose !== 1'b1 || digits_entered !== 4'd1 || score !== sc(8'h04)) begin
      bad++;
      $display("FAIL lose_hold: got loose=%b de=%0d score=%h want 1 1 %h",
               loose, digits_entered, score, sc(8'h04));
    end
  endtask

  task automatic test_timeout_race();
    do_enable();
    do_shl(5'd4);
    do_shl(5'd4);
    do_bt();
    do_key(4'd4);
    time_stop = 1'b1;
    do_key(4'd4);
    time_stop = 1'b0;
    total++;
    if (win !== 1'b1 || loose !== 1'b0) begin
      bad++;
      $display("FAIL race_win: got win=%b loose=%b want 1 0", win, loose);
    end
    do_enable();
    do_shl(5'd4);
    do_shl(5'd4);
    do_bt();
    do_key(4'd4);
    time_stop = 1'b1;
    cyc();
    time_stop = 1'b0;
    total++;
    if (loose !== 1'b1 || win !== 1'b0 || digits_entered !== 4'd1) begin
      bad++;
      $display("FAIL timeout: got loose=%b win=%b de=%0d want 1 0 1", loose, win, digits_entered);
    end
    total++;
    if (score !== sc(8'h07)) begin
      bad++;
      $display("FAIL timeout_score: got %h want %h", score, sc(8'h07));
    end
  endtask

  task automatic test_boundaries();
    do_enable();
    for (int i = 0; i < 9; i++) do_shl(5'(i));
    total++;
    if (expected_cnt !== 4'd8) begin
      bad++;
      $display("FAIL saturate: got %0d want 8", expected_cnt);
    end
    do_key(4'd0);
    total++;
    if (digits_entered !== 4'd0 || loose !== 1'b0) begin
      bad++;
      $display("FAIL key_in_capture: got de=%0d loose=%b want 0 0", digits_entered, loose);
    end
    do_bt();
    for (int i = 0; i < 8; i++) do_key(4'(i));
    total++;
    if (win !== 1'b1 || digits_entered !== 4'd8 || score !== sc(8'h15)) begin
      bad++;
      $display("FAIL full_seq: got win=%b de=%0d score=%h want 1 8 %h",
               win, digits_entered, score, sc(8'h15));
    end
    do_enable();
    do_bt();
    total++;
    if (loose !== 1'b1 || win !== 1'b0 || expected_cnt !== 4'd0) begin
      bad++;
      $display("FAIL empty_seq: got loose=%b win=%b ec=%0d want 1 0 0", loose, win, expected_cnt);
    end
    do_enable();
    shl         = 1'b1;
    flash_num   = 5'd6;
    begin_timer = 1'b1;
    cyc();
    shl         = 1'b0;
    begin_timer = 1'b0;
    total++;
    if (expected_cnt !== 4'd1 || loose !== 1'b0) begin
      bad++;
      $display("FAIL shl_bt: got ec=%0d loose=%b want 1 0", expected_cnt, loose);
    end
    do_key(4'd6);
    total++;
    if (win !== 1'b1 || score !== sc(8'h16)) begin
      bad++;
      $display("FAIL shl_bt_win: got win=%b score=%h want 1 %h", win, score, sc(8'h16));
    end
  endtask

  task automatic test_abort();
    do_enable();
    do_shl(5'd1);
    do_shl(5'd2);
    do_shl(5'd3);
    do_bt();
    do_key(4'd1);
    do_key(4'd2);
    logout = 1'b1;
    cyc();
    logout = 1'b0;
    total++;
    if ({win, loose, digits_entered, expected_cnt, score} !== 18'd0) begin
      bad++;
      $display("FAIL abort: got win=%b loose=%b de=%0d ec=%0d score=%h want all 0",
               win, loose, digits_entered, expected_cnt, score);
    end
    do_enable();
    do_shl(5'd9);
    total++;
    if (expected_cnt !== 4'd1) begin
      bad++;
      $display("FAIL abort_restart: got ec=%0d want 1", expected_cnt);
    end
    do_bt();
    do_key(4'd9);
    total++;
    if (win !== 1'b1 || score !== sc(8'h01)) begin
      bad++;
      $display("FAIL abort_win: got win=%b score=%h want 1 %h", win, score, sc(8'h01));
    end
  endtask

  task automatic test_reset_in_win();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    total++;
    if ({win, loose, digits_entered, expected_cnt, score} !== 18'd0) begin
      bad++;
      $display("FAIL reset_win: got win=%b loose=%b de=%0d ec=%0d score=%h want all 0",
               win, loose, digits_entered, expected_cnt, score);
    end
    do_shl(5'd2);
    total++;
    if (expected_cnt !== 4'd0) begin
      bad++;
      $display("FAIL idle_shl: got ec=%0d want 0", expected_cnt);
    end
    do_enable();
    do_shl(5'd2);
    total++;
    if (expected_cnt !== 4'd1) begin
      bad++;
      $display("FAIL post_reset: got ec=%0d want 1", expected_cnt);
    end
  endtask

  initial begin
    rst         = 1'b0;
    enable      = 1'b0;
    shl         = 1'b0;
    flash_num   = '0;
    begin_timer = 1'b0;
    key_valid   = 1'b0;
    key_code    = '0;
    time_stop   = 1'b0;
    logout      = 1'b0;
    test_reset();
    test_match();
    test_mismatch();
    test_timeout_race();
    test_boundaries();
    test_abort();
    test_reset_in_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
